bounded_counter: RTL and testbench

- Loadable up/down counter that the overflow assertion monitor observes.
- Drives data_out from ld/inc/dec/data_in.
- Detects overflow (inc at all-ones) and underflow (dec at zero).
- Either wraps or saturates at the boundary, selected by parameter.
- Reports each event as a single-cycle pulse, a sticky flag and a saturating event count, so the assertion, the testbench and software can all cross-check boundary handling.

---
 rtl/bounded_counter.sv | 101 ++++++++++
 tb/tb_bounded_counter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/bounded_counter.sv
// Loadable up/down counter with overflow/underflow detection, wrap or saturate at the boundary.
// Latency: data_out and event pulses update one clk edge after the command.
// Backpressure: none; every command is accepted on every cycle.
//
// Ports:
//   clk, rst         rising-edge clock; synchronous active-low reset
//   ld, data_in      load data_in (highest priority, never raises an event)
//   inc, dec         step requests; both together means hold
//   clr_sticky       clears sticky flags and event counters (a same-cycle event still lands)
//   data_out         registered count; at_max / at_min decode it combinationally
//   ovf_*/udf_*      one-cycle pulse, sticky flag and saturating count per event kind
module bounded_counter #(
  parameter int WIDTH    = 3,
  parameter int SATURATE = 0,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic             inc,
  input  logic             dec,
  input  logic [WIDTH-1:0] data_in,
  input  logic             clr_sticky,
  output logic [WIDTH-1:0] data_out,
  output logic             at_max,
  output logic             at_min,
  output logic             ovf_pulse,
  output logic             udf_pulse,
  output logic             ovf_sticky,
  output logic             udf_sticky,
  output logic [CNT_W-1:0] ovf_count,
  output logic [CNT_W-1:0] udf_count
);

  localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             step_up;
  logic             step_dn;
  logic             ovf_ev;
  logic             udf_ev;
  logic [WIDTH-1:0] next_q;

  assign at_max = (data_out == MAX_VAL);
  assign at_min = (data_out == '0);

  // Exactly one of inc/dec, and no load, makes a step; events are judged on
  // the current value so a load of a boundary value never counts as one.
  assign step_up = ~ld & inc & ~dec;
  assign step_dn = ~ld & dec & ~inc;
  assign ovf_ev  = step_up & at_max;
  assign udf_ev  = step_dn & at_min;

  always_comb begin
    next_q = data_out;
    if (ld) begin
      next_q = data_in;
    end else if (ovf_ev) begin
      next_q = (SATURATE != 0) ? MAX_VAL : '0;
    end else if (udf_ev) begin
      next_q = (SATURATE != 0) ? '0 : MAX_VAL;
    end else if (step_up) begin
      next_q = data_out + 1'b1;
    end else if (step_dn) begin
      next_q = data_out - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      data_out   <= '0;
      ovf_pulse  <= 1'b0;
      udf_pulse  <= 1'b0;
      ovf_sticky <= 1'b0;
      udf_sticky <= 1'b0;
      ovf_count  <= '0;
      udf_count  <= '0;
    end else begin
      data_out  <= next_q;
      ovf_pulse <= ovf_ev;
      udf_pulse <= udf_ev;

      // Set beats clear: an event coinciding with clr_sticky leaves flag=1, count=1.
      ovf_sticky <= ovf_ev | (ovf_sticky & ~clr_sticky);
      udf_sticky <= udf_ev | (udf_sticky & ~clr_sticky);

      if (clr_sticky) begin
        ovf_count <= ovf_ev ? CNT_W'(1) : '0;
      end else if (ovf_ev && ovf_count != CNT_MAX) begin
        ovf_count <= ovf_count + CNT_W'(1);
      end

      if (clr_sticky) begin
        udf_count <= udf_ev ? CNT_W'(1) : '0;
      end else if (udf_ev && udf_count != CNT_MAX) begin
        udf_count <= udf_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_bounded_counter.sv
// Bench for bounded_counter: a wrapping and a saturating instance share stimulus.
// A behavioural model pushes expected outputs per driven command; they are popped
// and compared one edge later, alongside hand-derived table values for the wrap instance.
module tb_bounded_counter;

  typedef struct packed {
    logic [2:0] q;
    logic       mx;
    logic       mn;
    logic       op;
    logic       up;
    logic       os;
    logic       us;
    logic [3:0] oc;
    logic [3:0] uc;
  } outs_t;

  typedef struct packed {
    outs_t w;
    outs_t s;
  } exp_t;

  typedef struct {
    logic       rst;
    logic       ld;
    logic       inc;
    logic       dec;
    logic [2:0] din;
    logic       clr;
    logic [2:0] eq;
    logic       eo;
    logic       eu;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ld = 1'b0;
  logic       inc = 1'b0;
  logic       dec = 1'b0;
  logic [2:0] data_in = 3'd0;
  logic       clr_sticky = 1'b0;

  logic [2:0] w_q, s_q;
  logic       w_mx, w_mn, w_op, w_up, w_os, w_us;
  logic       s_mx, s_mn, s_op, s_up, s_os, s_us;
  logic [3:0] w_oc, w_uc, s_oc, s_uc;

  outs_t obs_w, obs_s;
  assign obs_w = {w_q, w_mx, w_mn, w_op, w_up, w_os, w_us, w_oc, w_uc};
  assign obs_s = {s_q, s_mx, s_mn, s_op, s_up, s_os, s_us, s_oc, s_uc};

  always #5 clk = ~clk;

  bounded_counter #(.WIDTH(3), .SATURATE(0), .CNT_W(4)) u_wrap (
    .clk(clk), .rst(rst), .ld(ld), .inc(inc), .dec(dec), .data_in(data_in),
    .clr_sticky(clr_sticky), .data_out(w_q), .at_max(w_mx), .at_min(w_mn),
    .ovf_pulse(w_op), .udf_pulse(w_up), .ovf_sticky(w_os), .udf_sticky(w_us),
    .ovf_count(w_oc), .udf_count(w_uc)
  );

  bounded_counter #(.WIDTH(3), .SATURATE(1), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .ld(ld), .inc(inc), .dec(dec), .data_in(data_in),
    .clr_sticky(clr_sticky), .data_out(s_q), .at_max(s_mx), .at_min(s_mn),
    .ovf_pulse(s_op), .udf_pulse(s_up), .ovf_sticky(s_os), .udf_sticky(s_us),
    .ovf_count(s_oc), .udf_count(s_uc)
  );

  int    n_vec = 0;
  int    n_bad = 0;
  exp_t  sb[$];
  outs_t mw = '0;
  outs_t ms = '0;
  vec_t  tbl[16];

  function automatic outs_t model(input outs_t c, input bit sat, input logic r, input logic l,
                                  input logic i, input logic d, input logic [2:0] di,
                                  input logic cl);
    outs_t n;
    logic  oe, ue;
    n = '0;
    if (r) begin
      oe = !l && i && !d && (c.q == 3'd7);
      ue = !l && d && !i && (c.q == 3'd0);
      if (l)             n.q = di;
      else if (oe)       n.q = sat ? 3'd7 : 3'd0;
      else if (ue)       n.q = sat ? 3'd0 : 3'd7;
      else if (i && !d)  n.q = c.q + 3'd1;
      else if (d && !i)  n.q = c.q - 3'd1;
      else               n.q = c.q;
      n.op = oe;
      n.up = ue;
      n.os = oe || (c.os && !cl);
      n.us = ue || (c.us && !cl);
      if (cl)                        n.oc = oe ? 4'd1 : 4'd0;
      else if (oe && c.oc != 4'd15)  n.oc = c.oc + 4'd1;
      else                           n.oc = c.oc;
      if (cl)                        n.uc = ue ? 4'd1 : 4'd0;
      else if (ue && c.uc != 4'd15)  n.uc = c.uc + 4'd1;
      else                           n.uc = c.uc;
    end
    n.mx = (n.q == 3'd7);
    n.mn = (n.q == 3'd0);
    return n;
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Drive one command on the falling edge, queue the model's prediction,
  // then check both instances just after the rising edge.
  task automatic apply(input logic r, input logic l, input logic i, input logic d,
                       input logic [2:0] di, input logic cl, input string tag);
    exp_t e;
    @(negedge clk);
    rst = r; ld = l; inc = i; dec = d; data_in = di; clr_sticky = cl;
    mw = model(mw, 1'b0, r, l, i, d, di, cl);
    ms = model(ms, 1'b1, r, l, i, d, di, cl);
    sb.push_back('{w: mw, s: ms});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    cmp({tag, "_wrap"}, 32'(obs_w), 32'(e.w));
    cmp({tag, "_sat"},  32'(obs_s), 32'(e.s));
  endtask

  initial begin
    int sat_pulses;
    // rst ld inc dec din clr | wrap: data_out ovf_pulse udf_pulse
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0}; // reset
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd5, 1'b0, 3'd5, 1'b0, 1'b0}; // load 5
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 3'd6, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 3'd7, 1'b0, 1'b0}; // at_max, no event
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 1'b0}; // overflow wraps
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0}; // pulse lasts one cycle
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 3'd7, 1'b0, 1'b1}; // underflow wraps
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd7, 1'b0, 3'd7, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 3'd2, 1'b0, 3'd2, 1'b0, 1'b0}; // ld beats inc at max
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 3'd2, 1'b0, 1'b0}; // inc+dec holds
    tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd7, 1'b0, 3'd7, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 3'd0, 1'b1, 1'b0}; // clr with overflow
    tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 3'd0, 1'b0, 1'b0}; // clr alone
    tbl[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd7, 1'b0, 3'd7, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0}; // reset beats inc at 7
    tbl[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0}; // no pulse after reset

    for (int k = 0; k < 16; k++) begin
      apply(tbl[k].rst, tbl[k].ld, tbl[k].inc, tbl[k].dec, tbl[k].din, tbl[k].clr,
            $sformatf("vec%0d", k));
      cmp($sformatf("tbl%0d_q", k), 32'(w_q), 32'(tbl[k].eq));
      cmp($sformatf("tbl%0d_pulses", k), 32'({w_op, w_up}), 32'({tbl[k].eo, tbl[k].eu}));
    end

    // Held dec from zero: saturating instance pulses every cycle and its count
    // pins at 15; the wrapping instance underflows on decs 1, 9 and 17 only.
    apply(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, "ld0");
    sat_pulses = 0;
    for (int k = 0; k < 20; k++) begin
      apply(1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, "dec_hold");
      if (s_up === 1'b1) sat_pulses++;
    end
    cmp("sat_udf_pulse_cycles", 32'(sat_pulses), 32'd20);
    cmp("sat_udf_count_sat", 32'(s_uc), 32'd15);
    cmp("sat_udf_sticky", 32'(s_us), 32'd1);
    cmp("sat_q_held_zero", 32'(s_q), 32'd0);
    cmp("wrap_udf_count", 32'(w_uc), 32'd3);

    // Random mix with occasional reset and clear.
    for (int k = 0; k < 400; k++) begin
      apply(($urandom_range(0, 31) != 0), ($urandom_range(0, 5) == 0),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            3'($urandom_range(0, 7)), ($urandom_range(0, 9) == 0), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
